// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline: memory wait, load-use and mult/div hazards.
// Optional perf counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULDIV_LAT  = 32,
    parameter int unsigned MEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic        muldiv_id,
    input  logic        hilo_rd_id,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    input  logic        perf_clr,
    output logic        en_if,
    output logic        en_id,
    output logic        en_ex,
    output logic        en_mem,
    output logic        bubble_ex,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt
);

    localparam int unsigned MdW   = $clog2(MULDIV_LAT + 1);
    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [MdW-1:0]     md_cnt_q;
    logic               timeout_q;

    logic mem_hold, md_hold, id_hold, md_active, md_issue, timeout_hit;

    assign md_active = (md_cnt_q != '0);
    assign mem_hold  = dmem_req_mem & ~dmem_ready;
    assign md_hold   = (muldiv_id | hilo_rd_id) & md_active;
    assign id_hold   = stall_id | md_hold;
    assign md_issue  = muldiv_id & en_id & ~bubble_ex;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StRun: begin
                if (mem_hold) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM / hazard outputs; everything forced low while reset is asserted
    always_comb begin
        en_if     = 1'b0;
        en_id     = 1'b0;
        en_ex     = 1'b0;
        en_mem    = 1'b0;
        bubble_ex = 1'b0;
        if (rst_n) begin
            if (mem_hold) begin
                bubble_ex = 1'b0;
            end else if (id_hold) begin
                en_id     = 1'b1;
                en_ex     = 1'b1;
                en_mem    = 1'b1;
                bubble_ex = 1'b1;
            end else begin
                en_if  = 1'b1;
                en_id  = 1'b1;
                en_ex  = 1'b1;
                en_mem = 1'b1;
            end
        end
    end

    assign timeout_hit = (state_q == StMemWait) && (wait_cnt_q == WaitW'(MEM_TIMEOUT));
    assign mem_timeout = timeout_q | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    // Mult/div keeps counting through memory stalls; the unit itself is never frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
        end else if (md_issue) begin
            md_cnt_q <= MdW'(MULDIV_LAT);
        end else if (md_active) begin
            md_cnt_q <= md_cnt_q - 1'b1;
        end
    end

    assign muldiv_busy = rst_n & md_active;
    assign muldiv_done = muldiv_busy & (md_cnt_q == MdW'(1));

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (perf_clr) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (mem_hold && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bubble_ex && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_stall_cnt  = 32'd0;
    assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then constrained-random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MdLat = 4;
    localparam int unsigned MemTo = 8;

    typedef logic [71:0] vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_id = 1'b0, muldiv_id = 1'b0, hilo_rd_id = 1'b0;
    logic        dmem_req_mem = 1'b0, dmem_ready = 1'b0, perf_clr = 1'b0;
    logic        en_if, en_id, en_ex, en_mem, bubble_ex;
    logic        muldiv_busy, muldiv_done, mem_timeout;
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;

    pipeline_hazard_ctrl #(
        .MULDIV_LAT (MdLat),
        .MEM_TIMEOUT(MemTo)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_id       (stall_id),
        .muldiv_id      (muldiv_id),
        .hilo_rd_id     (hilo_rd_id),
        .dmem_req_mem   (dmem_req_mem),
        .dmem_ready     (dmem_ready),
        .perf_clr       (perf_clr),
        .en_if          (en_if),
        .en_id          (en_id),
        .en_ex          (en_ex),
        .en_mem         (en_mem),
        .bubble_ex      (bubble_ex),
        .muldiv_busy    (muldiv_busy),
        .muldiv_done    (muldiv_done),
        .mem_timeout    (mem_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    vec_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;

    // Reference model: remaining mult/div cycles, length of the ongoing memory wait, totals
    int     md_rem = 0;
    int     wait_run = 0;
    bit     to_sticky = 1'b0;
    longint p_stall = 0;
    longint p_bubble = 0;

    task automatic step(input bit rst, input bit s, input bit m, input bit h,
                        input bit q, input bit r, input bit c);
        vec_t     e;
        bit       busy, done, mh, ih, to, bub;
        bit [3:0] en;
        @(posedge clk);
        #1;
        if (rst && wait_run > 0) q = 1'b1;
        rst_n        = rst;
        stall_id     = s;
        muldiv_id    = m;
        hilo_rd_id   = h;
        dmem_req_mem = q;
        dmem_ready   = r;
        perf_clr     = c;
        if (!rst) begin
            md_rem    = 0;
            wait_run  = 0;
            to_sticky = 1'b0;
            p_stall   = 0;
            p_bubble  = 0;
            exp_q.push_back('0);
            return;
        end
        busy = (md_rem > 0);
        done = (md_rem == 1);
        mh   = q && !r;
        ih   = s || ((m || h) && busy);
        to   = to_sticky || (wait_run >= int'(MemTo));
        if (mh) begin
            en  = 4'b0000;
            bub = 1'b0;
        end else if (ih) begin
            en  = 4'b0111;
            bub = 1'b1;
        end else begin
            en  = 4'b1111;
            bub = 1'b0;
        end
        e = {en, bub, busy, done, to, 32'(p_stall), 32'(p_bubble)};
        exp_q.push_back(e);
        to_sticky = to;
        if (m && !mh && !ih) md_rem = MdLat;
        else if (md_rem > 0) md_rem--;
        wait_run = mh ? wait_run + 1 : 0;
`ifdef PIPE_CTRL_PERF_CNT_EN
        if (c) begin
            p_stall  = 0;
            p_bubble = 0;
        end else begin
            if (mh && p_stall < 64'hFFFF_FFFF) p_stall++;
            if (bub && p_bubble < 64'hFFFF_FFFF) p_bubble++;
        end
`endif
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle
    initial begin
        vec_t e, act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {en_if, en_id, en_ex, en_mem, bubble_ex, muldiv_busy, muldiv_done,
                       mem_timeout, perf_stall_cnt, perf_bubble_cnt};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, e);
                end
            end
        end
    end

    initial begin
        bit s, m, h, q, r, c, rs;
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        // reset release, idle
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        // single load-use stall
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // three-cycle memory wait
        repeat (3) step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // mult/div issue then MFHI held behind it
        step(1, 0, 1, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // long wait reaching the timeout
        repeat (10) step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 1);
        // async reset in the middle of a wait with mult/div busy
        step(1, 0, 1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 1, 0, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        // constrained-random traffic
        for (int i = 0; i < 1500; i++) begin
            rs = ($urandom_range(199) != 0);
            s  = ($urandom_range(5) == 0);
            m  = ($urandom_range(4) == 0);
            h  = ($urandom_range(4) == 0);
            c  = ($urandom_range(29) == 0);
            if (wait_run > 0) begin
                q = 1'b1;
                r = (wait_run > 15) || ($urandom_range(5) == 0);
            end else begin
                q = ($urandom_range(3) == 0);
                r = $urandom_range(1) != 0;
            end
            step(rs, s, m, h, q, r, c);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d entries left required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
